// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
// SIPO_RX_PARITY_EN adds the PARITY framing state.
package sipo_pkg;

  localparam int WIDTH_DEFAULT = 4;

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;
`else
  typedef enum logic {
    ST_DATA = 1'b0
  } state_t;
`endif

endpackage

// File: rtl/sipo_out_buf.sv
// Valid/ready holding register for completed words, with sticky overrun
// when a word arrives while the previous one is still unconsumed.
module sipo_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_perr,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun,
  output logic             perr
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             overrun_reg;
  logic             perr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      perr_reg    <= 1'b0;
    end else if (load) begin
      // A handshake on the completing edge frees the slot for the new word.
      if (!valid_reg || ready) begin
        data_reg  <= load_data;
        perr_reg  <= load_perr;
        valid_reg <= 1'b1;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign data    = data_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;
  assign perr    = perr_reg;

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver, MSB first, with sync-based reframing.
// Define SIPO_RX_PARITY_EN to expect an even-parity bit after each word.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sync,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  state_t           state_reg;

  logic             take_bit;
  logic             last_data;
  logic [WIDTH-1:0] shift_next;
  logic             word_done;
  logic [WIDTH-1:0] word_data;
  logic             word_perr;
  logic             buf_perr;

  assign take_bit   = shift_en && !sync;
  assign last_data  = (bit_cnt_reg == CNT_W'(WIDTH - 1));
  assign shift_next = {shift_reg[WIDTH-2:0], serial_in};

`ifdef SIPO_RX_PARITY_EN
  // The word is already fully shifted in; the parity bit completes it.
  always_comb begin
    word_done = take_bit && (state_reg == ST_PARITY);
    word_data = shift_reg;
    word_perr = ^{shift_reg, serial_in};
  end
`else
  always_comb begin
    word_done = take_bit && (state_reg == ST_DATA) && last_data;
    word_data = shift_next;
    word_perr = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || sync) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      state_reg   <= ST_DATA;
    end else if (take_bit) begin
`ifdef SIPO_RX_PARITY_EN
      if (state_reg == ST_PARITY) begin
        state_reg <= ST_DATA;
      end else begin
        shift_reg   <= shift_next;
        bit_cnt_reg <= last_data ? '0 : bit_cnt_reg + CNT_W'(1);
        if (last_data) begin
          state_reg <= ST_PARITY;
        end
      end
`else
      shift_reg   <= shift_next;
      bit_cnt_reg <= last_data ? '0 : bit_cnt_reg + CNT_W'(1);
      state_reg   <= ST_DATA;
`endif
    end
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (word_done),
    .load_data(word_data),
    .load_perr(word_perr),
    .ready    (out_ready),
    .data     (parallel_out),
    .valid    (out_valid),
    .overrun  (overrun),
    .perr     (buf_perr)
  );

`ifdef SIPO_RX_PARITY_EN
  assign parity_err = buf_perr;
`else
  assign parity_err = 1'b0 & buf_perr;
`endif

endmodule
